// File: rtl/uart_pkg.sv
// Shared UART constants: default payload width, frame bit positions and parity mode.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  // Frame layout: [0]=start, [DATA_W:1]=data LSB-first, [DATA_W+1]=parity, [DATA_W+2]=stop.
  localparam int START_IDX  = 0;
  localparam int DATA_LSB   = 1;
  localparam int PARITY_IDX = UART_DATA_W + 1;
  localparam int STOP_IDX   = UART_DATA_W + 2;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  function automatic int frame_w(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int parity_idx(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int stop_idx(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/uart_parity_chk.sv
// Combinational parity checker: flags a data word whose parity bit disagrees with the mode.
module uart_parity_chk
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  output logic              err
);

  localparam parity_mode_e MODE = PARITY_ODD ? PAR_ODD : PAR_EVEN;

  logic p;

  // Even mode expects the total count of ones to be even, odd mode expects it odd.
  assign p   = (^data) ^ parity;
  assign err = (MODE == PAR_ODD) ? ~p : p;

endmodule

// File: rtl/uart_deframe.sv
// Splits an assembled RX frame into registered fields with parity/framing checks
// and a one-cycle done pulse per captured frame.
module uart_deframe
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_valid,
  input  logic [DATA_W+3-1:0]     data_parll,
  output logic [DATA_W-1:0]       data_out,
  output logic                    start_bit,
  output logic                    parity_bit,
  output logic                    stop_bit,
  output logic                    done_flag,
  output logic                    parity_err,
  output logic                    frame_err
);

  localparam int FRAME_W = frame_w(DATA_W);
  localparam int PAR_IDX = parity_idx(DATA_W);
  localparam int STP_IDX = stop_idx(DATA_W);

  logic [DATA_W-1:0] data_field;
  logic              start_field;
  logic              parity_field;
  logic              stop_field;
  logic              par_chk_err;
  logic              parity_err_next;
  logic              frame_err_next;

  assign start_field  = data_parll[START_IDX];
  assign data_field   = data_parll[DATA_W+DATA_LSB-1:DATA_LSB];
  assign parity_field = data_parll[PAR_IDX];
  assign stop_field   = data_parll[STP_IDX];

  uart_parity_chk #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) u_parity_chk (
    .data   (data_field),
    .parity (parity_field),
    .err    (par_chk_err)
  );

  // The parity bit is still captured when checking is disabled; only the flag is masked.
  assign parity_err_next = PARITY_EN ? par_chk_err : 1'b0;
  assign frame_err_next  = start_field | ~stop_field;

  // Reset values describe an idle line: start/stop read as mark (1), payload cleared.
  // NOTE: sequential state uses non-blocking assignments so every output samples the
  // same pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      start_bit  <= 1'b1;
      parity_bit <= 1'b0;
      stop_bit   <= 1'b1;
      done_flag  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done_flag <= frame_valid;
      if (frame_valid) begin
        data_out   <= data_field;
        start_bit  <= start_field;
        parity_bit <= parity_field;
        stop_bit   <= stop_field;
        parity_err <= parity_err_next;
        frame_err  <= frame_err_next;
      end
    end
  end

  if (FRAME_W != DATA_W + 3) begin : g_bad_width
    $error("uart_deframe: frame width derivation mismatch");
  end

endmodule

// File: tb/tb_uart_deframe.sv
// Directed bench for uart_deframe: even, odd and parity-disabled instances share stimulus.
module tb_uart_deframe;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               frame_valid = 1'b0;
  logic [FRAME_W-1:0] data_parll = '0;

  logic [DATA_W-1:0] e_data, o_data, n_data;
  logic e_start, e_par, e_stop, e_done, e_perr, e_ferr;
  logic o_start, o_par, o_stop, o_done, o_perr, o_ferr;
  logic n_start, n_par, n_stop, n_done, n_perr, n_ferr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_deframe #(.DATA_W(DATA_W), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .data_parll(data_parll),
    .data_out(e_data), .start_bit(e_start), .parity_bit(e_par), .stop_bit(e_stop),
    .done_flag(e_done), .parity_err(e_perr), .frame_err(e_ferr));

  uart_deframe #(.DATA_W(DATA_W), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .data_parll(data_parll),
    .data_out(o_data), .start_bit(o_start), .parity_bit(o_par), .stop_bit(o_stop),
    .done_flag(o_done), .parity_err(o_perr), .frame_err(o_ferr));

  uart_deframe #(.DATA_W(DATA_W), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_nopar (
    .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .data_parll(data_parll),
    .data_out(n_data), .start_bit(n_start), .parity_bit(n_par), .stop_bit(n_stop),
    .done_flag(n_done), .parity_err(n_perr), .frame_err(n_ferr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Checks every output of the even-parity instance against hand-computed values.
  task automatic check_even(input string tag, input logic [7:0] data, input logic st,
                            input logic par, input logic sp, input logic done,
                            input logic perr, input logic ferr);
    check({tag, ".data"},  32'(e_data),  32'(data));
    check({tag, ".start"}, 32'(e_start), 32'(st));
    check({tag, ".par"},   32'(e_par),   32'(par));
    check({tag, ".stop"},  32'(e_stop),  32'(sp));
    check({tag, ".done"},  32'(e_done),  32'(done));
    check({tag, ".perr"},  32'(e_perr),  32'(perr));
    check({tag, ".ferr"},  32'(e_ferr),  32'(ferr));
  endtask

  // Presents one frame for a single cycle; returns #1 after the capturing edge.
  task automatic send(input logic [FRAME_W-1:0] frame);
    @(negedge clk);
    data_parll  = frame;
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset with garbage on the bus, checked before any clock edge.
    data_parll = 11'h5B3;
    #1 rst_n = 1'b0;
    #2;
    check_even("reset", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset.odd_data", 32'(o_data), 32'h0);
    check("reset.nopar_stop", 32'(n_stop), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Good frame, then done drops after one cycle.
    send(11'h54A);
    check_even("good", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("good.odd_perr", 32'(o_perr), 32'h1);
    next_cycle();
    check("good.done_drop", 32'(e_done), 32'h0);
    check("good.data_hold", 32'(e_data), 32'hA5);

    // Parity bit flipped: even flags, odd accepts, disabled never flags.
    send(11'h74A);
    check_even("perr", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("perr.odd_perr", 32'(o_perr), 32'h0);
    check("perr.nopar_perr", 32'(n_perr), 32'h0);
    check("perr.nopar_par", 32'(n_par), 32'h1);
    check("perr.odd_data", 32'(o_data), 32'hA5);

    // Framing errors: missing stop, then bad start.
    send(11'h14A);
    check_even("stop0", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(11'h54B);
    check_even("start1", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Restore a known good capture, then hold against random bus traffic.
    send(11'h54A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      data_parll = FRAME_W'($urandom);
      @(posedge clk);
      #1;
      check("hold.data", 32'(e_data), 32'hA5);
      check("hold.done", 32'(e_done), 32'h0);
    end
    check_even("hold.final", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back captures with no dead cycle.
    @(negedge clk);
    data_parll = 11'h54A; frame_valid = 1'b1;
    next_cycle();
    check_even("b2b0", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    data_parll = 11'h002;
    next_cycle();
    check_even("b2b1", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("b2b1.odd_perr", 32'(o_perr), 32'h0);
    @(negedge clk);
    data_parll = 11'h7FF;
    next_cycle();
    check_even("b2b2", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("b2b2.nopar_perr", 32'(n_perr), 32'h0);
    @(negedge clk);
    frame_valid = 1'b0;
    next_cycle();
    check("b2b.done_drop", 32'(e_done), 32'h0);
    check("b2b.data_hold", 32'(e_data), 32'hFF);

    // Async reset right after a capture, observed before the next edge.
    send(11'h54A);
    #2 rst_n = 1'b0;
    #1;
    check_even("async_rst", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Frame presented while reset is held: no capture, no done.
    @(negedge clk);
    data_parll = 11'h54A; frame_valid = 1'b1;
    next_cycle();
    check_even("rst_hold", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    frame_valid = 1'b0;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
